pframe: RTL
===========

PFRAME -- requirements
Module: pframe

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning the maximum payload bytes per frame (legal range 1..255).
REQ-002 SHALL have port i_clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port i_data  input  8  byte stream; one byte every cycle, with no input valid.
REQ-005 SHALL have port i_sync  input  1  sync-word detect pulse from the upstream pattern detector; high in cycle t means i_data in cycle t is the first byte after the sync word.
REQ-006 SHALL have port o_data  output  8  payload byte.
REQ-007 SHALL have port o_valid  output  1  o_data/o_last valid.
REQ-008 SHALL have port i_ready  input  1  downstream accepts; a transfer occurs when o_valid && i_ready.
REQ-009 SHALL have port o_last  output  1  marks the final payload byte of a frame.
REQ-010 SHALL have port o_frame_cnt  output  16  good frames accepted, saturating.
REQ-011 SHALL have port o_err_cnt  output  16  frames rejected for bad length or checksum, saturating.
REQ-012 SHALL have port o_drop_cnt  output  16  syncs ignored while draining, saturating.

Function
REQ-013 SHALL parse frames as: LEN byte (on the i_sync cycle), then LEN payload bytes, then one checksum byte equal to the XOR of the payload bytes.
REQ-014 SHALL implement FSM states IDLE, PAYLOAD, CHECK and DRAIN, with one byte consumed per cycle in IDLE, PAYLOAD and CHECK.
REQ-015 IDLE with i_sync and 1<=i_data<=MAX_LEN SHALL latch LEN, clear the write index and XOR accumulator, and go to PAYLOAD.
REQ-016 IDLE with i_sync and i_data==0 or i_data>MAX_LEN SHALL increment o_err_cnt and stay in IDLE.
REQ-017 PAYLOAD SHALL write i_data to buffer[wr], XOR it into the accumulator and increment wr each cycle, moving to CHECK in the cycle the LEN-th byte is written.
REQ-018 CHECK SHALL compare i_data to the accumulator: on a match, increment o_frame_cnt, clear rd and go to DRAIN; on a mismatch, increment o_err_cnt and go to IDLE.
REQ-019 i_sync SHALL be ignored in PAYLOAD and CHECK, because payload bytes may contain the sync word.
REQ-020 DRAIN SHALL hold o_valid=1, o_data=buffer[rd] and o_last=(rd==LEN-1), advancing rd only on a transfer.
REQ-021 A transfer with o_last=1 SHALL return the FSM to IDLE in the next cycle; o_valid SHALL then be 0.
REQ-022 o_data and o_last SHALL stay stable while o_valid && !i_ready.
REQ-023 i_sync in DRAIN SHALL increment o_drop_cnt, and that frame SHALL NOT be parsed.
REQ-024 A sync coinciding with the final DRAIN transfer SHALL count as dropped; there is no back-to-back capture.
REQ-025 o_valid SHALL be 0 in IDLE, PAYLOAD and CHECK.
REQ-026 Every counter SHALL hold at 16'hFFFF once reached.
REQ-027 The buffer SHALL be MAX_LEN x 8 bits; the wr, rd and LEN registers SHALL be $clog2(MAX_LEN+1) bits wide.
REQ-028 The XOR accumulator SHALL be 8 bits.

Reset
REQ-029 Asserting i_rst_n=0 SHALL immediately force state=IDLE, o_valid=0, o_last=0, o_data=0 and clear all counters, wr, rd, LEN and the accumulator.
REQ-030 Buffer contents SHALL be don't-care after reset.
REQ-031 Reset mid-frame or mid-DRAIN SHALL abandon the frame silently, with no counter increment.
REQ-032 The block SHALL resume parsing on the first i_sync after reset deasserts.

Verification
REQ-033 Sync, then bytes 03,11,22,33,00 with i_ready=1 -> o_data 11,22,33 on consecutive cycles, o_last only on 33; o_frame_cnt=1.
REQ-034 Sync, then bytes 02,AA,55,00 -> bad checksum (expected FF) -> no o_valid; o_err_cnt=1.
REQ-035 Sync with LEN 00, then a second sync with LEN 11 (MAX_LEN=16) -> both rejected; o_err_cnt=2; FSM stays IDLE.
REQ-036 Good 2-byte frame with i_ready toggling 0,1,0,1 -> each byte held stable until accepted; exactly 2 transfers.
REQ-037 i_sync pulsed during DRAIN with i_ready=0 -> o_drop_cnt=1; after the drain completes, o_valid=0 and there is no second frame.
REQ-038 i_rst_n pulsed low during PAYLOAD -> outputs and counters go to 0 asynchronously; the next good frame is received correctly.

Source files
------------

// File: rtl/pframe.sv
// pframe: sync-aligned frame parser (LEN, payload, XOR checksum) that
// buffers a whole frame and releases it over a valid/ready stream.
module pframe #(
    parameter int MAX_LEN = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_sync,
    input  logic        i_ready,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_last,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_err_cnt,
    output logic [15:0] o_drop_cnt
);
    localparam int W  = $clog2(MAX_LEN + 1);
    localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, DRAIN} state_t;

    state_t       state, state_nx;
    logic [7:0]   mem [MAX_LEN];
    logic [W-1:0] len, wr, rd;
    logic [7:0]   acc;
    logic         len_ok, sum_ok, xfer, start;

    function automatic logic [15:0] sat(input logic [15:0] c, input logic inc);
        return (inc && c != 16'hFFFF) ? c + 16'd1 : c;
    endfunction

    assign len_ok = i_data != 8'd0 && i_data <= 8'(MAX_LEN);
    assign sum_ok = i_data == acc;
    assign xfer   = o_valid && i_ready;
    assign start  = state == IDLE && i_sync && len_ok;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? PAYLOAD : IDLE;
            PAYLOAD: state_nx = wr == len - 1'b1 ? CHECK : PAYLOAD;
            CHECK:   state_nx = sum_ok ? DRAIN : IDLE;
            DRAIN:   state_nx = xfer && o_last ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from state so reset clears them without a clock.
    always_comb begin
        o_valid = state == DRAIN;
        o_data  = o_valid ? mem[rd[AW-1:0]] : 8'd0;
        o_last  = o_valid && rd == len - 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (state == PAYLOAD)
            mem[wr[AW-1:0]] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len         <= '0;
            wr          <= '0;
            rd          <= '0;
            acc         <= '0;
            o_frame_cnt <= '0;
            o_err_cnt   <= '0;
            o_drop_cnt  <= '0;
        end else begin
            if (start) begin
                len <= i_data[W-1:0];
                wr  <= '0;
                acc <= '0;
            end
            if (state == PAYLOAD) begin
                wr  <= wr + 1'b1;
                acc <= acc ^ i_data;
            end
            if (state == CHECK && sum_ok)
                rd <= '0;
            else if (xfer && !o_last)
                rd <= rd + 1'b1;
            o_frame_cnt <= sat(o_frame_cnt, state == CHECK && sum_ok);
            o_err_cnt   <= sat(o_err_cnt, (state == IDLE && i_sync && !len_ok) || (state == CHECK && !sum_ok));
            o_drop_cnt  <= sat(o_drop_cnt, state == DRAIN && i_sync);
        end
    end
endmodule
